// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC ownership, instruction memory reads, stall/redirect handling
//
// Ports:
//   CLK, RESET                 clock; asynchronous active-high reset
//   STALL                      hazard stall: hold PC, keep IF/ID blocked
//   BRANCH_TAKEN/TARGET        redirect from EX (target bits [1:0] ignored)
//   IMEM_READ/ADDRESS          instruction memory request
//   IMEM_READDATA/BUSYWAIT     instruction memory response
//   OUT_PC/OUT_INSTRUCTION     to IF/ID register
//   FETCH_BUSYWAIT             to IF/ID BUSYWAIT (1 = IF/ID must not load)
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] OUT_PC,
    output logic [31:0] OUT_INSTRUCTION,
    output logic        FETCH_BUSYWAIT
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] discard_addr, discard_addr_next;
    logic [31:0] held_instr, held_instr_next;

    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {BRANCH_TARGET[31:2], 2'b00};
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            discard_addr <= RESET_PC;
            held_instr   <= NOP_INSTR;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            discard_addr <= discard_addr_next;
            held_instr   <= held_instr_next;
        end
    end

    always_comb begin
        state_next        = state;
        pc_next           = pc;
        discard_addr_next = discard_addr;
        held_instr_next   = held_instr;

        IMEM_READ       = 1'b0;
        IMEM_ADDRESS    = pc;
        OUT_PC          = pc;
        OUT_INSTRUCTION = NOP_INSTR;
        FETCH_BUSYWAIT  = 1'b1;

        case (state)
            S_FETCH: begin
                IMEM_READ       = 1'b1;
                IMEM_ADDRESS    = pc;
                OUT_INSTRUCTION = IMEM_READDATA;
                FETCH_BUSYWAIT  = IMEM_BUSYWAIT | STALL;
                if (BRANCH_TAKEN && IMEM_BUSYWAIT) begin
                    // The in-flight read must finish at its original address
                    // before the target can be requested.
                    discard_addr_next = pc;
                    pc_next           = target;
                    state_next        = S_DISCARD;
                end else if (BRANCH_TAKEN) begin
                    pc_next = target;
                end else if (!IMEM_BUSYWAIT && STALL) begin
                    // Keep the completed word so the stall never re-reads memory.
                    held_instr_next = IMEM_READDATA;
                    state_next      = S_HOLD;
                end else if (!IMEM_BUSYWAIT) begin
                    pc_next = pc_plus4;
                end
            end

            S_HOLD: begin
                IMEM_READ       = 1'b0;
                IMEM_ADDRESS    = pc;
                OUT_INSTRUCTION = held_instr;
                FETCH_BUSYWAIT  = STALL;
                if (BRANCH_TAKEN) begin
                    pc_next    = target;
                    state_next = S_FETCH;
                end else if (!STALL) begin
                    pc_next    = pc_plus4;
                    state_next = S_FETCH;
                end
            end

            S_DISCARD: begin
                IMEM_READ       = 1'b1;
                IMEM_ADDRESS    = discard_addr;
                OUT_INSTRUCTION = NOP_INSTR;
                FETCH_BUSYWAIT  = 1'b1;
                // A further redirect while draining replaces the pending target.
                if (BRANCH_TAKEN) begin
                    pc_next = target;
                end
                if (!IMEM_BUSYWAIT) begin
                    state_next = S_FETCH;
                end
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase

        // A redirect always pushes a bubble into IF/ID, even over a stall.
        if (BRANCH_TAKEN) begin
            OUT_INSTRUCTION = NOP_INSTR;
            FETCH_BUSYWAIT  = 1'b0;
        end

        // Reset outputs apply immediately, independent of the clock.
        if (RESET) begin
            IMEM_READ       = 1'b0;
            IMEM_ADDRESS    = RESET_PC;
            OUT_PC          = RESET_PC;
            OUT_INSTRUCTION = NOP_INSTR;
            FETCH_BUSYWAIT  = 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] OUT_PC;
    logic [31:0] OUT_INSTRUCTION;
    logic        FETCH_BUSYWAIT;

    int n_checks;
    int n_fail;

    instruction_fetch_unit dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .STALL           (STALL),
        .BRANCH_TAKEN    (BRANCH_TAKEN),
        .BRANCH_TARGET   (BRANCH_TARGET),
        .IMEM_READ       (IMEM_READ),
        .IMEM_ADDRESS    (IMEM_ADDRESS),
        .IMEM_READDATA   (IMEM_READDATA),
        .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
        .OUT_PC          (OUT_PC),
        .OUT_INSTRUCTION (OUT_INSTRUCTION),
        .FETCH_BUSYWAIT  (FETCH_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        RESET         = 1'b1;
        STALL         = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'h0;
        IMEM_READDATA = 32'h0;
        IMEM_BUSYWAIT = 1'b0;

        // Reset state
        #2;
        chk("rst_read",  {31'b0, IMEM_READ}, 32'd0);
        chk("rst_addr",  IMEM_ADDRESS, 32'h0);
        chk("rst_pc",    OUT_PC, 32'h0);
        chk("rst_instr", OUT_INSTRUCTION, NOP);
        chk("rst_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd1);
        cyc();
        cyc();
        RESET = 1'b0;
        #1;
        chk("first_read", {31'b0, IMEM_READ}, 32'd1);
        chk("first_addr", IMEM_ADDRESS, 32'h0);

        // Zero-wait sequential fetch
        IMEM_READDATA = 32'h0050_0093;
        #1;
        chk("seq0_pc",    OUT_PC, 32'h0);
        chk("seq0_instr", OUT_INSTRUCTION, 32'h0050_0093);
        chk("seq0_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        cyc();
        IMEM_READDATA = 32'h0010_0113;
        #1;
        chk("seq1_pc",    OUT_PC, 32'h4);
        chk("seq1_addr",  IMEM_ADDRESS, 32'h4);
        chk("seq1_instr", OUT_INSTRUCTION, 32'h0010_0113);
        chk("seq1_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        cyc();

        // Stall into HOLD while the word at 0x8 returns
        IMEM_READDATA = 32'h0020_81B3;
        STALL         = 1'b1;
        #1;
        chk("seq2_pc",    OUT_PC, 32'h8);
        chk("seq2_instr", OUT_INSTRUCTION, 32'h0020_81B3);
        chk("stall_fbw",  {31'b0, FETCH_BUSYWAIT}, 32'd1);
        cyc();
        IMEM_READDATA = 32'hDEAD_BEEF;
        #1;
        chk("hold_read",  {31'b0, IMEM_READ}, 32'd0);
        chk("hold_instr", OUT_INSTRUCTION, 32'h0020_81B3);
        chk("hold_pc",    OUT_PC, 32'h8);
        chk("hold_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd1);
        cyc();
        STALL = 1'b0;
        #1;
        chk("release_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        chk("release_instr", OUT_INSTRUCTION, 32'h0020_81B3);
        cyc();
        #1;
        chk("after_hold_addr", IMEM_ADDRESS, 32'hC);
        chk("after_hold_read", {31'b0, IMEM_READ}, 32'd1);
        cyc();

        // Wait states at 0x10
        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_fbw",  {31'b0, FETCH_BUSYWAIT}, 32'd1);
            chk("wait_addr", IMEM_ADDRESS, 32'h10);
            cyc();
        end
        IMEM_BUSYWAIT = 1'b0;
        IMEM_READDATA = 32'h1234_5678;
        #1;
        chk("ready_addr",  IMEM_ADDRESS, 32'h10);
        chk("ready_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        chk("ready_instr", OUT_INSTRUCTION, 32'h1234_5678);
        cyc();
        #1;
        chk("post_wait_addr", IMEM_ADDRESS, 32'h14);
        cyc();
        cyc();
        cyc();

        // Redirect during busy read at 0x20
        #1;
        chk("pre_redir_addr", IMEM_ADDRESS, 32'h20);
        IMEM_BUSYWAIT = 1'b1;
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h100;
        #1;
        chk("redir_instr", OUT_INSTRUCTION, NOP);
        chk("redir_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        cyc();
        BRANCH_TAKEN = 1'b0;
        #1;
        chk("disc_addr",  IMEM_ADDRESS, 32'h20);
        chk("disc_read",  {31'b0, IMEM_READ}, 32'd1);
        chk("disc_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd1);
        chk("disc_instr", OUT_INSTRUCTION, NOP);
        cyc();
        IMEM_BUSYWAIT = 1'b0;
        #1;
        chk("disc_done_addr", IMEM_ADDRESS, 32'h20);
        chk("disc_done_fbw",  {31'b0, FETCH_BUSYWAIT}, 32'd1);
        cyc();
        IMEM_READDATA = 32'h1111_1111;
        #1;
        chk("tgt_addr",  IMEM_ADDRESS, 32'h100);
        chk("tgt_pc",    OUT_PC, 32'h100);
        chk("tgt_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        chk("tgt_instr", OUT_INSTRUCTION, 32'h1111_1111);
        cyc();

        // Unaligned target is forced to word alignment; redirect with ready memory
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h203;
        cyc();
        BRANCH_TAKEN = 1'b0;
        #1;
        chk("align_addr", IMEM_ADDRESS, 32'h200);

        // PC wrap
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        cyc();
        BRANCH_TAKEN = 1'b0;
        #1;
        chk("wrap_pre_addr", IMEM_ADDRESS, 32'hFFFF_FFFC);
        cyc();
        #1;
        chk("wrap_addr", IMEM_ADDRESS, 32'h0);

        // Redirect from HOLD with STALL still high
        STALL         = 1'b1;
        IMEM_READDATA = 32'hAAAA_5555;
        cyc();
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h40;
        #1;
        chk("hold_br_read",  {31'b0, IMEM_READ}, 32'd0);
        chk("hold_br_instr", OUT_INSTRUCTION, NOP);
        chk("hold_br_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        cyc();
        BRANCH_TAKEN = 1'b0;
        STALL        = 1'b0;
        #1;
        chk("hold_br_addr", IMEM_ADDRESS, 32'h40);
        chk("hold_br_rd",   {31'b0, IMEM_READ}, 32'd1);

        // Asynchronous reset while in DISCARD
        IMEM_BUSYWAIT = 1'b1;
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h80;
        cyc();
        BRANCH_TAKEN = 1'b0;
        #1;
        chk("disc2_addr", IMEM_ADDRESS, 32'h40);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_read",  {31'b0, IMEM_READ}, 32'd0);
        chk("arst_addr",  IMEM_ADDRESS, 32'h0);
        chk("arst_pc",    OUT_PC, 32'h0);
        chk("arst_instr", OUT_INSTRUCTION, NOP);
        chk("arst_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd1);
        cyc();
        RESET         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        IMEM_READDATA = 32'h0050_0093;
        #1;
        chk("post_rst_addr",  IMEM_ADDRESS, 32'h0);
        chk("post_rst_read",  {31'b0, IMEM_READ}, 32'd1);
        chk("post_rst_fbw",   {31'b0, FETCH_BUSYWAIT}, 32'd0);
        chk("post_rst_instr", OUT_INSTRUCTION, 32'h0050_0093);
        cyc();
        #1;
        chk("post_rst_next", IMEM_ADDRESS, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
